// File: rtl/arb_fifo_pkg.sv
// Shared helpers for the weighted round-robin FIFO arbiter.
package arb_fifo_pkg;

   // Upper bounds for the helper function argument widths; callers zero-extend.
   localparam int MAX_REQS = 32;
   localparam int MAX_QW   = 16;

   typedef struct packed {
      logic       found;
      logic [4:0] idx;
   } rr_pick_t;

   // First set bit of elig scanning cyclically from cur+1 over n channels.
   // cur itself is visited last, so a lone eligible channel can re-win.
   function automatic rr_pick_t next_rr(input logic [MAX_REQS-1:0] elig,
                                        input int unsigned cur,
                                        input int unsigned n);
      rr_pick_t    r;
      int unsigned i;
      r = '0;
      for (int unsigned k = 1; k <= MAX_REQS; k++) begin
         if (k <= n && !r.found) begin
            i = (cur + k) % n;
            if (elig[i[4:0]]) begin
               r.found = 1'b1;
               r.idx   = i[4:0];
            end
         end
      end
      return r;
   endfunction

   // Deficit loaded on a channel switch: max(q,1)-1 (the granting word is paid for).
   function automatic logic [MAX_QW-1:0] qload(input logic [MAX_QW-1:0] q);
      return (q == '0) ? '0 : q - 1'b1;
   endfunction

endpackage

// File: rtl/occ_fifo.sv
// Single-clock FIFO with registered full/empty/count; pointers wrap at DEPTH.
module occ_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int OW   = $clog2(DEPTH+1),
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [OW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [OW-1:0]    count_q, count_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // Next-state: a pop on a full FIFO frees the slot for a same-cycle push.
   always_comb begin
      do_pop  = pop & ~empty_q;
      do_push = push & (~full_q | do_pop);
      mem_d   = mem_q;
      if (do_push) mem_d[wr_q] = din;
      wr_d    = do_push ? inc(wr_q) : wr_q;
      rd_d    = do_pop  ? inc(rd_q) : rd_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == OW'(DEPTH));
      empty_d = (count_d == '0);
   end

   // Pointer/flag registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // Storage; no reset needed, writes suppressed during reset.
   always_ff @(posedge clk) begin
      if (rst) mem_q <= mem_d;
   end

   assign dout  = mem_q[rd_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/wrr_fifo_arbiter.sv
// Per-channel FIFOs served by a deficit-weighted round-robin onto one registered stream.
module wrr_fifo_arbiter
   import arb_fifo_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int QWID     = 4,
   localparam int CW      = $clog2(NUM_REQS),
   localparam int OW      = $clog2(DEPTH+1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQS-1:0]       push,
   input  logic [NUM_REQS*WIDTH-1:0] flat_data_in,
   input  logic [NUM_REQS-1:0]       reqs,
   input  logic [NUM_REQS*QWID-1:0]  quantums,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]          data_out,
   output logic [CW-1:0]             out_chan,
   output logic [NUM_REQS-1:0]       gnt,
   output logic [NUM_REQS-1:0]       empty,
   output logic [NUM_REQS-1:0]       full,
   output logic [NUM_REQS*OW-1:0]    count,
   output logic [NUM_REQS-1:0]       overflow
);

   logic [NUM_REQS-1:0][WIDTH-1:0] head;
   logic [NUM_REQS-1:0][QWID-1:0]  q_arr;
   logic [NUM_REQS-1:0][QWID-1:0]  def_q, def_d;
   logic [CW-1:0]                  cur_q, cur_d, sel;
   logic                           out_valid_q, out_valid_d;
   logic [WIDTH-1:0]               data_q, data_d;
   logic [CW-1:0]                  chan_q, chan_d;
   logic [NUM_REQS-1:0]            ovf_q, ovf_d;
   logic [NUM_REQS-1:0]            elig, gnt_c;
   logic [MAX_REQS-1:0]            elig_ext;
   logic [MAX_QW-1:0]              q_ext, q_ld;
   logic                           adv, any_g;
   rr_pick_t                       pick;

   assign q_arr = quantums;

   genvar g;
   generate
      for (g = 0; g < NUM_REQS; g++) begin : g_fifo
         occ_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .din   (flat_data_in[g*WIDTH +: WIDTH]),
            .pop   (gnt_c[g]),
            .dout  (head[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .count (count[g*OW +: OW])
         );
      end
   endgenerate

   // Arbitration: stay on cur while it has deficit, else forfeit and move to next eligible.
   always_comb begin
      elig     = reqs & ~empty;
      adv      = ~out_valid_q | out_ready;
      elig_ext = '0;
      elig_ext[NUM_REQS-1:0] = elig;
      pick     = next_rr(elig_ext, 32'(cur_q), NUM_REQS);
      gnt_c    = '0;
      cur_d    = cur_q;
      def_d    = def_q;
      sel      = '0;
      any_g    = 1'b0;
      q_ext    = '0;
      q_ld     = '0;
      if (rst && adv) begin
         if (elig[cur_q] && def_q[cur_q] != '0) begin
            sel          = cur_q;
            any_g        = 1'b1;
            def_d[cur_q] = def_q[cur_q] - 1'b1;
         end else if (pick.found) begin
            sel          = CW'(pick.idx);
            any_g        = 1'b1;
            def_d[cur_q] = '0;
            cur_d        = sel;
            q_ext[QWID-1:0] = q_arr[sel];
            q_ld         = qload(q_ext);
            def_d[sel]   = q_ld[QWID-1:0];
         end
         gnt_c[sel] = any_g;
      end
   end

   // Output register loads on a grant, drains when accepted with nothing to send.
   always_comb begin
      out_valid_d = out_valid_q;
      data_d      = data_q;
      chan_d      = chan_q;
      if (adv) begin
         out_valid_d = any_g;
         if (any_g) begin
            data_d = head[sel];
            chan_d = sel;
         end
      end
      ovf_d = ovf_q | (push & full & ~gnt_c);
   end

   // Arbiter state, output stage and sticky overflow flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cur_q       <= CW'(NUM_REQS-1);
         def_q       <= '0;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         chan_q      <= '0;
         ovf_q       <= '0;
      end else begin
         cur_q       <= cur_d;
         def_q       <= def_d;
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         chan_q      <= chan_d;
         ovf_q       <= ovf_d;
      end
   end

   assign gnt       = gnt_c;
   assign out_valid = out_valid_q;
   assign data_out  = data_q;
   assign out_chan  = chan_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_wrr_fifo_arbiter.sv
// Directed bench for wrr_fifo_arbiter: reset, latency, weighting, backpressure,
// overflow, full push+pop and zero-quantum skipping.
module tb_wrr_fifo_arbiter;

   localparam int NR = 4;
   localparam int W  = 8;
   localparam int D  = 8;
   localparam int QW = 4;
   localparam int CW = 2;
   localparam int OW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     push;
   logic [NR*W-1:0]   din;
   logic [NR-1:0]     reqs;
   logic [NR*QW-1:0]  quantums;
   logic              out_ready;
   logic              out_valid;
   logic [W-1:0]      data_out;
   logic [CW-1:0]     out_chan;
   logic [NR-1:0]     gnt, empty, full, overflow;
   logic [NR*OW-1:0]  count;

   int nchk = 0;
   int nerr = 0;

   logic [7:0] got_c[$], got_d[$], exp_c[$], exp_d[$];

   wrr_fifo_arbiter #(.NUM_REQS(NR), .WIDTH(W), .DEPTH(D), .QWID(QW)) dut (
      .clk(clk), .rst(rst), .push(push), .flat_data_in(din), .reqs(reqs),
      .quantums(quantums), .out_ready(out_ready), .out_valid(out_valid),
      .data_out(data_out), .out_chan(out_chan), .gnt(gnt), .empty(empty),
      .full(full), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [OW-1:0] cnt(input int ch);
      return count[ch*OW +: OW];
   endfunction

   task automatic do_reset();
      rst  = 1'b0;
      push = 4'hF;
      reqs = '0;
      tick();
      tick();
      rst  = 1'b1;
      push = '0;
   endtask

   // Record every accepted word (out_ready held high) until n words or the budget runs out.
   task automatic collect(input int n);
      int got = 0;
      int cyc = 0;
      out_ready = 1'b1;
      #1;
      while (got < n && cyc < 200) begin
         if (out_valid) begin
            got_c.push_back(8'(out_chan));
            got_d.push_back(data_out);
            got++;
            if (got == n) break;
         end
         tick();
         cyc++;
      end
      if (got < n) chk("collect_timeout", 32'(got), 32'(n));
   endtask

   task automatic cmp_stream(input string tag);
      for (int i = 0; i < exp_c.size(); i++) begin
         chk($sformatf("%s_chan%0d", tag, i),
             (i < got_c.size()) ? 32'(got_c[i]) : 32'hFFFF_FFFF, 32'(exp_c[i]));
         chk($sformatf("%s_data%0d", tag, i),
             (i < got_d.size()) ? 32'(got_d[i]) : 32'hFFFF_FFFF, 32'(exp_d[i]));
      end
      got_c.delete(); got_d.delete(); exp_c.delete(); exp_d.delete();
   endtask

   initial begin
      rst = 1'b0; push = '0; din = '0; reqs = '0; quantums = {NR{4'd1}}; out_ready = 1'b1;

      // Reset with pushes and requests asserted: everything discarded.
      rst = 1'b0; push = 4'hF; reqs = 4'hF; din = 32'h1122_3344;
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      tick();
      chk("rst_empty", 32'(empty), 32'hF);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_chan", 32'(out_chan), 32'h0);
      rst = 1'b1; push = '0; reqs = '0;

      // Latency: single word on ch2.
      reqs = 4'hF; out_ready = 1'b1;
      push = 4'b0100; din = '0; din[2*W +: W] = 8'hA5;
      tick();
      push = '0;
      #1;
      chk("lat_gnt", 32'(gnt), 32'h4);
      chk("lat_cnt", 32'(cnt(2)), 32'd1);
      chk("lat_empty", 32'(empty), 32'hB);
      chk("lat_valid0", 32'(out_valid), 32'h0);
      tick();
      chk("lat_valid1", 32'(out_valid), 32'h1);
      chk("lat_data", 32'(data_out), 32'hA5);
      chk("lat_chan", 32'(out_chan), 32'd2);
      chk("lat_cnt_after", 32'(cnt(2)), 32'd0);
      tick();
      chk("lat_valid_clr", 32'(out_valid), 32'h0);

      // Weighting ch0:3, ch1:1, with a 5-cycle stall mid-stream.
      do_reset();
      quantums = {4'd1, 4'd1, 4'd1, 4'd3};
      reqs = '0;
      for (int k = 0; k < 8; k++) begin
         push = 4'b0011; din = '0;
         din[0 +: W] = 8'(k);
         din[W +: W] = 8'(8'h10 + k);
         tick();
      end
      push = '0;
      chk("wt_full", 32'(full), 32'h3);
      reqs = 4'hF;
      collect(4);
      tick();
      out_ready = 1'b0;
      #1;
      chk("bp_gnt0", 32'(gnt), 32'h0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("bp_data%0d", c), 32'(data_out), 32'h03);
         chk($sformatf("bp_chan%0d", c), 32'(out_chan), 32'd0);
         chk($sformatf("bp_valid%0d", c), 32'(out_valid), 32'h1);
         chk($sformatf("bp_gnt%0d", c), 32'(gnt), 32'h0);
         chk($sformatf("bp_cnt0_%0d", c), 32'(cnt(0)), 32'd4);
         chk($sformatf("bp_cnt1_%0d", c), 32'(cnt(1)), 32'd7);
      end
      collect(12);
      exp_c = '{0,0,0,1, 0,0,0,1, 0,0,1,1, 1,1,1,1};
      exp_d = '{8'h00,8'h01,8'h02,8'h10, 8'h03,8'h04,8'h05,8'h11,
                8'h06,8'h07,8'h12,8'h13, 8'h14,8'h15,8'h16,8'h17};
      cmp_stream("wt");

      // Overflow: 9 pushes into an 8-deep FIFO with no service.
      do_reset();
      quantums = {NR{4'd1}};
      reqs = '0;
      for (int k = 1; k <= 9; k++) begin
         push = 4'b0001; din = '0; din[0 +: W] = 8'(k);
         tick();
         if (k == 8) begin
            chk("ovf_full8", 32'(full[0]), 32'h1);
            chk("ovf_cnt8", 32'(cnt(0)), 32'd8);
            chk("ovf_flag8", 32'(overflow[0]), 32'h0);
         end
      end
      push = '0;
      chk("ovf_flag9", 32'(overflow), 32'h1);
      chk("ovf_cnt9", 32'(cnt(0)), 32'd8);
      reqs = 4'b0001;
      collect(8);
      exp_c = '{0,0,0,0,0,0,0,0};
      exp_d = '{8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7,8'd8};
      cmp_stream("ovf");
      tick(); tick();
      chk("ovf_sticky", 32'(overflow[0]), 32'h1);
      chk("ovf_empty", 32'(empty), 32'hF);
      chk("ovf_idle", 32'(out_valid), 32'h0);

      // Full FIFO: same-cycle push and pop keeps the pushed word.
      do_reset();
      reqs = '0;
      for (int k = 1; k <= 8; k++) begin
         push = 4'b0100; din = '0; din[2*W +: W] = 8'(8'h20 + k);
         tick();
      end
      chk("fp_full", 32'(full), 32'h4);
      reqs = 4'b0100; push = 4'b0100; din = '0; din[2*W +: W] = 8'h99;
      #1;
      chk("fp_gnt", 32'(gnt), 32'h4);
      tick();
      push = '0;
      chk("fp_cnt", 32'(cnt(2)), 32'd8);
      chk("fp_ovf", 32'(overflow), 32'h0);
      collect(9);
      exp_c = '{2,2,2,2,2,2,2,2,2};
      exp_d = '{8'h21,8'h22,8'h23,8'h24,8'h25,8'h26,8'h27,8'h28,8'h99};
      cmp_stream("fp");

      // Zero quantum with skipped channels: ch1 and ch3 alternate.
      do_reset();
      quantums = '0;
      reqs = '0;
      for (int k = 0; k < 4; k++) begin
         push = 4'hF;
         for (int c = 0; c < NR; c++) din[c*W +: W] = 8'((c << 4) | k);
         tick();
      end
      push = '0;
      reqs = 4'b1010;
      collect(6);
      exp_c = '{1,3,1,3,1,3};
      exp_d = '{8'h10,8'h30,8'h11,8'h31,8'h12,8'h32};
      cmp_stream("zq");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
